// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter
// Purpose  : Iterative multiplier/divider, one operand bit per cycle.
//            Ops: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
//            Fixed latency: accept edge -> CALC (WIDTH cycles) -> FIXUP (1 cycle)
//            -> DONE, i.e. out_valid in the (WIDTH+2)th cycle after accept.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous active-high reset
//            in_valid   - operand set offered
//            in_ready   - block idle, can accept operands
//            a, b       - operands (WIDTH bits)
//            op         - operation select (3 bits)
//            out_valid  - res holds a completed result
//            out_ready  - consumer takes the result
//            res        - result (WIDTH bits), registered
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res
);

  localparam int            c_CW       = $clog2(WIDTH + 1);
  localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(WIDTH);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(1);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_CALC  = 2'd1;
  localparam logic [1:0] c_S_FIXUP = 2'd2;
  localparam logic [1:0] c_S_DONE  = 2'd3;

  localparam logic [2:0] c_OP_MUL    = 3'd0;
  localparam logic [2:0] c_OP_MULH   = 3'd1;
  localparam logic [2:0] c_OP_MULHSU = 3'd2;
  localparam logic [2:0] c_OP_MULHU  = 3'd3;
  localparam logic [2:0] c_OP_DIV    = 3'd4;
  localparam logic [2:0] c_OP_DIVU   = 3'd5;
  localparam logic [2:0] c_OP_REM    = 3'd6;
  localparam logic [2:0] c_OP_REMU   = 3'd7;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [c_CW-1:0]  cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  // op2 holds the multiplicand (mul) or the divisor (div).
  logic [WIDTH-1:0] op2_q, op2_d;
  // hi: product high half / partial remainder. lo: multiplier / dividend,
  // shifted out as the product low half / quotient is built.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_q, neg_d;       // operand signs differ
  logic             neg_rem_q, neg_rem_d; // dividend was negative
  logic             dbz_q, dbz_d;       // divide by zero
  logic [WIDTH-1:0] res_q, res_d;

  // --------------------------------------------------------------------------
  // Operand decode at accept time
  // --------------------------------------------------------------------------
  logic             w_is_div;
  logic             w_a_sgn;
  logic             w_b_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_is_div = op[2];
  assign w_a_sgn  = (op == c_OP_MUL) || (op == c_OP_MULH) || (op == c_OP_MULHSU) ||
                    (op == c_OP_DIV) || (op == c_OP_REM);
  assign w_b_sgn  = (op == c_OP_MUL) || (op == c_OP_MULH) ||
                    (op == c_OP_DIV) || (op == c_OP_REM);
  assign w_a_neg  = w_a_sgn && a[WIDTH-1];
  assign w_b_neg  = w_b_sgn && b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  // --------------------------------------------------------------------------
  // One iteration step
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_diff;

  // Shift-add: conditionally add multiplicand into the high half, then shift
  // the whole {carry, hi, lo} right by one.
  assign w_mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op2_q} : {(WIDTH+1){1'b0}});
  // Restoring divide: bring in the next dividend bit and trial-subtract.
  // When the subtract succeeds the difference is below the divisor, so the
  // low WIDTH bits of the shifted value are enough for it.
  assign w_div_shift = {hi_q, lo_q[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, op2_q});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - op2_q;

  // --------------------------------------------------------------------------
  // Sign fixup and result selection
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_result;

  assign w_prod     = {hi_q, lo_q};
  assign w_prod_fix = neg_q ? -w_prod : w_prod;
  // A zero divisor yields an all-ones quotient regardless of dividend sign;
  // the remainder path naturally reproduces a (magnitude, re-signed).
  assign w_quo_fix  = dbz_q ? {WIDTH{1'b1}} : (neg_q ? -lo_q : lo_q);
  assign w_rem_fix  = neg_rem_q ? -hi_q : hi_q;

  always_comb begin
    w_result = w_prod_fix[WIDTH-1:0];
    case (op_q)
      c_OP_MUL:                           w_result = w_prod_fix[WIDTH-1:0];
      c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_result = w_prod_fix[2*WIDTH-1:WIDTH];
      c_OP_DIV, c_OP_DIVU:                w_result = w_quo_fix;
      c_OP_REM, c_OP_REMU:                w_result = w_rem_fix;
      default:                            w_result = w_prod_fix[WIDTH-1:0];
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= c_S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_S_IDLE:  if (in_valid)              state_d = c_S_CALC;
      c_S_CALC:  if (cnt_q == c_CNT_LAST)   state_d = c_S_FIXUP;
      c_S_FIXUP:                            state_d = c_S_DONE;
      c_S_DONE:  if (out_ready)             state_d = c_S_IDLE;
      default:                              state_d = c_S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      c_S_IDLE: in_ready  = 1'b1;
      c_S_DONE: out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign res = res_q;

  // --------------------------------------------------------------------------
  // Datapath next state
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    op2_d     = op2_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    res_d     = res_q;
    case (state_q)
      c_S_IDLE: begin
        if (in_valid) begin
          cnt_d     = c_CNT_LOAD;
          op_d      = op;
          op2_d     = w_is_div ? w_b_mag : w_a_mag;
          lo_d      = w_is_div ? w_a_mag : w_b_mag;
          hi_d      = '0;
          neg_d     = w_a_neg ^ w_b_neg;
          neg_rem_d = w_a_neg;
          dbz_d     = w_is_div && (b == '0);
        end
      end
      c_S_CALC: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q[2]) begin
          hi_d = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], w_div_ge};
        end else begin
          hi_d = w_mul_sum[WIDTH:1];
          lo_d = {w_mul_sum[0], lo_q[WIDTH-1:1]};
        end
      end
      c_S_FIXUP: begin
        res_d = w_result;
      end
      default: begin
        res_d = res_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      op_q      <= '0;
      op2_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      res_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      op2_q     <= op2_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      res_q     <= res_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_iter
// Purpose  : Self-checking bench for muldiv_iter (WIDTH = 32). A negedge
//            monitor tracks every accepted operation, predicts the result
//            from plain arithmetic and checks handshake timing, latency,
//            result value and hold stability. Directed cases pin the model
//            to hand-computed values; random cases exercise all ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter;

  localparam int         W    = 32;
  localparam int         LAT  = W + 2;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] res;

  int nvec  = 0;
  int nfail = 0;

  muldiv_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic: products in double width, divides in 64-bit signed.
  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [2:0] o);
    logic [2*W-1:0] xs, xu, ys, yu, p;
    longint         sx, sy;
    logic [W-1:0]   r;
    xs = {{W{x[W-1]}}, x};
    xu = {{W{1'b0}}, x};
    ys = {{W{y[W-1]}}, y};
    yu = {{W{1'b0}}, y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = '0;
    p  = '0;
    case (o)
      3'd0: begin p = xs * ys; r = p[W-1:0];   end
      3'd1: begin p = xs * ys; r = p[2*W-1:W]; end
      3'd2: begin p = xs * yu; r = p[2*W-1:W]; end
      3'd3: begin p = xu * yu; r = p[2*W-1:W]; end
      3'd4: begin
        if (y == '0)                      r = '1;
        else if (x == MINV && y == '1)    r = x;
        else                              r = W'(sx / sy);
      end
      3'd5: r = (y == '0) ? '1 : x / y;
      3'd6: begin
        if (y == '0)                      r = x;
        else if (x == MINV && y == '1)    r = '0;
        else                              r = W'(sx % sy);
      end
      default: r = (y == '0) ? x : x % y;
    endcase
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Monitor: every cycle, at the falling edge
  // --------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  bit           busy = 1'b0;
  int           lat  = 0;
  logic [W-1:0] held = '0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      busy = 1'b0;
      lat  = 0;
    end else if (busy) begin
      lat++;
      check("in_ready_busy", 64'(in_ready), 64'd0);
      if (lat < LAT) begin
        check("out_valid_early", 64'(out_valid), 64'd0);
      end else begin
        check("out_valid_at_latency", 64'(out_valid), 64'd1);
        if (lat == LAT) held = res;
        else            check("res_stable", 64'(res), 64'(held));
        if (exp_q.size() > 0) check("res_model", 64'(res), 64'(exp_q[0]));
        if (out_valid && out_ready) begin
          busy = 1'b0;
          void'(exp_q.pop_front());
        end
      end
    end else begin
      check("in_ready_idle", 64'(in_ready), 64'd1);
      check("out_valid_idle", 64'(out_valid), 64'd0);
      if (in_valid) begin
        exp_q.push_back(model(a, b, op));
        busy = 1'b1;
        lat  = 0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks (called from posedge+1 context)
  // --------------------------------------------------------------------------
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                       input logic [2:0] top, output int tries);
    bit ok;
    ok    = 1'b0;
    tries = 0;
    a = ta; b = tb2; op = top; in_valid = 1'b1;
    while (!ok && tries < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (!ok) tries++;
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    a  = $urandom;
    b  = $urandom;
    op = 3'($urandom);
  endtask

  task automatic take(input int hold, output logic [W-1:0] r);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("result_timeout", 64'd0, 64'd1);
    r = res;
    repeat (hold) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic directed(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb2,
                          input logic [2:0] top, input logic [W-1:0] ex);
    int           t;
    logic [W-1:0] r;
    check({nm, "_model"}, 64'(model(ta, tb2, top)), 64'(ex));
    issue(ta, tb2, top, t);
    take(0, r);
    check(nm, 64'(r), 64'(ex));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return W'(1);
      2:       return '1;
      3:       return MINV;
      4:       return ~MINV;
      5:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int           t;
    logic [W-1:0] r;

    #1 reset = 1'b1;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_res", 64'(res), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // First operation after reset: accepted on the first edge, latency pinned.
    issue(32'd3, 32'd5, 3'd0, t);
    check("first_accept_after_reset", 64'(t), 64'd0);
    take(0, r);
    check("mul_3x5", 64'(r), 64'd15);

    directed("mul_3xm5",    32'd3, 32'hFFFFFFFB, 3'd0, 32'hFFFFFFF1);
    directed("mulh_3xm5",   32'd3, 32'hFFFFFFFB, 3'd1, 32'hFFFFFFFF);
    directed("mulhu_3xm5",  32'd3, 32'hFFFFFFFB, 3'd3, 32'd2);
    directed("mulhsu_3xm5", 32'd3, 32'hFFFFFFFB, 3'd2, 32'd2);
    directed("div_m7_2",    32'hFFFFFFF9, 32'd2, 3'd4, 32'hFFFFFFFD);
    directed("rem_m7_2",    32'hFFFFFFF9, 32'd2, 3'd6, 32'hFFFFFFFF);
    directed("divu_7_2",    32'd7, 32'd2, 3'd5, 32'd3);
    directed("remu_7_2",    32'd7, 32'd2, 3'd7, 32'd1);
    directed("div_5_0",     32'd5, 32'd0, 3'd4, 32'hFFFFFFFF);
    directed("remu_5_0",    32'd5, 32'd0, 3'd7, 32'd5);
    directed("div_ovf",     32'h80000000, 32'hFFFFFFFF, 3'd4, 32'h80000000);
    directed("rem_ovf",     32'h80000000, 32'hFFFFFFFF, 3'd6, 32'd0);
    directed("divu_m5_0",   32'hFFFFFFFB, 32'd0, 3'd5, 32'hFFFFFFFF);
    directed("rem_m5_0",    32'hFFFFFFFB, 32'd0, 3'd6, 32'hFFFFFFFB);

    // Backpressure: hold out_ready low for 10 cycles after out_valid rises.
    issue(32'd1000, 32'd7, 3'd4, t);
    take(10, r);
    check("backpressure_res", 64'(r), 64'd142);
    @(negedge clk);
    check("in_ready_after_take", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Reset in cycle 10 of CALC abandons the operation.
    issue(32'd1234, 32'd77, 3'd0, t);
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midop_rst_in_ready", 64'(in_ready), 64'd1);
    check("midop_rst_out_valid", 64'(out_valid), 64'd0);
    check("midop_rst_res", 64'(res), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    issue(32'd3, 32'd5, 3'd0, t);
    check("accept_after_midop_rst", 64'(t), 64'd0);
    take(0, r);
    check("mul_after_midop_rst", 64'(r), 64'd15);

    // Random operations; the monitor checks every result against the model.
    for (int i = 0; i < 250; i++) begin
      issue(pick(), pick(), 3'($urandom_range(0, 7)), t);
      take(int'($urandom_range(0, 3)), r);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  // Global time bound.
  initial begin
    #600000;
    check("global_timeout", 64'd0, 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
